// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: debounced pushbutton control, speed-selectable prescaler,
// and four LED patterns driven from a small IDLE/RUN/PAUSE state machine.
module led_seq_ctrl #(
    parameter int unsigned BASE_DIV  = 2_500_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [7:0] LEDG
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [31:0] BASE_W = 32'(BASE_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic       w_rst_n;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_press;
    logic       w_run;
    logic       w_step;
    logic       w_clr;
    logic       w_unused;

    assign w_rst_n  = KEY[0];
    assign w_run    = w_press[0];
    assign w_step   = w_press[1];
    assign w_clr    = w_press[2];
    assign w_unused = ^SW[5:2];

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= KEY[3:1];
            r_sync2 <= r_sync1;
        end
    end

    // One pulse per press: the counter saturates and the key disarms until it reads high again.
    for (genvar g = 0; g < 3; g++) begin : g_db
        logic [DBW-1:0] r_cnt;
        logic           r_armed;

        assign w_press[g] = r_armed & ~r_sync2[g] & (r_cnt == DB_LAST);

        always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (r_sync2[g]) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (w_press[g]) begin
                r_armed <= 1'b0;
            end else if (r_armed) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    state_t      r_state, w_state_n;
    logic [1:0]  r_mode, w_mode_n;
    logic        r_dir, w_dir_n;
    logic [7:0]  r_pat, w_pat_n;
    logic [7:0]  r_ledg, w_ledg_n;
    logic [31:0] r_presc, w_presc_n;
    logic [31:0] r_limit, w_limit_n;
    logic [31:0] w_limit;
    logic        w_tick;
    logic        w_adv;
    logic [7:0]  w_adv_pat;
    logic        w_adv_dir;
    logic [7:0]  w_init_pat;

    assign w_limit    = BASE_W * (32'(SW[9:6]) + 32'd1) - 32'd1;
    assign w_tick     = (r_state == S_RUN) && (r_presc == r_limit);
    assign w_init_pat = SW[1] ? 8'h00 : 8'h01;

    always_comb begin
        w_adv_pat = r_pat;
        w_adv_dir = r_dir;
        case (r_mode)
            2'd0: w_adv_pat = {r_pat[6:0], r_pat[7]};
            2'd1: begin
                if (r_pat == 8'h80) begin
                    w_adv_dir = 1'b0;
                end else if (r_pat == 8'h01) begin
                    w_adv_dir = 1'b1;
                end
                w_adv_pat = w_adv_dir ? (r_pat << 1) : (r_pat >> 1);
            end
            2'd2: w_adv_pat = r_pat + 8'd1;
            default: w_adv_pat = r_pat ^ (8'd1 << r_ledg[2:0]);
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_mode_n  = r_mode;
        w_dir_n   = r_dir;
        w_pat_n   = r_pat;
        w_ledg_n  = r_ledg;
        w_presc_n = r_presc;
        w_limit_n = r_limit;
        w_adv     = 1'b0;
        if (w_clr) begin
            w_state_n = S_IDLE;
            w_pat_n   = 8'h00;
            w_ledg_n  = 8'h00;
            w_presc_n = 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_run) begin
                        w_state_n = S_RUN;
                        w_mode_n  = SW[1:0];
                        w_dir_n   = 1'b1;
                        w_pat_n   = w_init_pat;
                        w_presc_n = 32'd0;
                        w_limit_n = w_limit;
                    end
                end
                S_RUN: begin
                    // A tick coinciding with a pause press still advances.
                    w_adv = w_tick;
                    if (w_run) begin
                        w_state_n = S_PAUSE;
                        w_presc_n = 32'd0;
                    end else if (w_tick) begin
                        w_presc_n = 32'd0;
                        w_limit_n = w_limit;
                    end else begin
                        w_presc_n = r_presc + 32'd1;
                    end
                end
                S_PAUSE: begin
                    if (w_run) begin
                        w_state_n = S_RUN;
                        w_presc_n = 32'd0;
                        w_limit_n = w_limit;
                    end else begin
                        w_adv = w_step;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
            if (w_adv) begin
                w_pat_n  = w_adv_pat;
                w_dir_n  = w_adv_dir;
                w_ledg_n = r_ledg + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_dir   <= 1'b1;
            r_pat   <= 8'h00;
            r_ledg  <= 8'h00;
            r_presc <= 32'd0;
            r_limit <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_mode  <= w_mode_n;
            r_dir   <= w_dir_n;
            r_pat   <= w_pat_n;
            r_ledg  <= w_ledg_n;
            r_presc <= w_presc_n;
            r_limit <= w_limit_n;
        end
    end

    assign LEDR = {r_state, r_pat};
    assign LEDG = r_ledg;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed and random key/switch stimulus against a
// reference model whose predicted LED changes are checked by a monitor.
module tb_led_seq_ctrl;
    localparam int BASE_DIV  = 4;
    localparam int DB_CYCLES = 2;
    localparam int W         = 50;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [7:0] ledg;

    led_seq_ctrl #(.BASE_DIV(BASE_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .SW      (sw),
        .LEDR    (ledr),
        .LEDG    (ledg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] exp_q[$];
    int           sq_run[$];
    int           sq_step[$];
    int           sq_clr[$];
    logic [17:0]  last_v   = '0;

    int          m_st   = 0;
    int          m_mode = 0;
    int          m_k    = 0;
    int          m_t    = 0;
    int          m_per  = BASE_DIV;
    logic [17:0] m_out  = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pattern after k advances in a mode, straight from the pattern definitions.
    function automatic logic [7:0] ref_pattern(input int st, input int mode, input int k);
        int         pos;
        int         flips;
        logic [7:0] p;
        p = 8'h00;
        if (st != 0) begin
            case (mode)
                0: p = 8'(1 << (k % 8));
                1: begin
                    pos = k % 14;
                    if (pos > 7) pos = 14 - pos;
                    p = 8'(1 << pos);
                end
                2: p = 8'(k % 256);
                default: begin
                    for (int b = 0; b < 8; b++) begin
                        flips = (k / 8) + ((b < (k % 8)) ? 1 : 0);
                        p[b] = ((flips % 2) == 1);
                    end
                end
            endcase
        end
        return p;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk) begin : ref_model
        logic        p_run;
        logic        p_step;
        logic        p_clr;
        logic        tick;
        logic [17:0] nout;
        cyc = cyc + 1;
        if (!key[0]) begin
            m_st  = 0;
            m_mode = 0;
            m_k   = 0;
            m_t   = 0;
            m_out = '0;
        end else begin
            p_run = 1'b0;
            p_step = 1'b0;
            p_clr = 1'b0;
            if (sq_run.size() > 0 && sq_run[0] == cyc) begin p_run = 1'b1; void'(sq_run.pop_front()); end
            if (sq_step.size() > 0 && sq_step[0] == cyc) begin p_step = 1'b1; void'(sq_step.pop_front()); end
            if (sq_clr.size() > 0 && sq_clr[0] == cyc) begin p_clr = 1'b1; void'(sq_clr.pop_front()); end
            tick = (m_st == 1) && (m_t + 1 == m_per);
            if (p_clr) begin
                m_st = 0;
                m_k  = 0;
                m_t  = 0;
            end else if (p_run) begin
                if (m_st == 0) begin
                    m_st   = 1;
                    m_mode = int'(sw[1:0]);
                    m_k    = 0;
                    m_t    = 0;
                    m_per  = BASE_DIV * (int'(sw[9:6]) + 1);
                end else if (m_st == 1) begin
                    if (tick) m_k++;
                    m_st = 2;
                    m_t  = 0;
                end else begin
                    m_st  = 1;
                    m_t   = 0;
                    m_per = BASE_DIV * (int'(sw[9:6]) + 1);
                end
            end else if (m_st == 1) begin
                if (tick) begin
                    m_k++;
                    m_t   = 0;
                    m_per = BASE_DIV * (int'(sw[9:6]) + 1);
                end else begin
                    m_t++;
                end
            end else if (m_st == 2 && p_step) begin
                m_k++;
            end
            nout = {2'(m_st), ref_pattern(m_st, m_mode, m_k), 8'(m_k % 256)};
            if (nout != m_out) begin
                exp_q.push_back({32'(cyc), nout});
                m_out = nout;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [17:0]  dut_v;
        logic [W-1:0] e;
        dut_v = {ledr, ledg};
        if (!key[0]) begin
            last_v = dut_v;
        end else begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q[0];
            if (exp_q.size() > 0 && (dut_v != last_v || int'(e[W-1:18]) <= cyc)) begin
                void'(exp_q.pop_front());
                chk("led_value", dut_v, e[17:0]);
                chk("led_cycle", cyc, e[W-1:18]);
            end else if (dut_v != last_v) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_change: got 0x%0h expected 0x%0h (cycle %0d)", dut_v, last_v, cyc);
            end
            last_v = dut_v;
        end
    end

    // ---------------- drivers (entered and left just after a falling edge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // keys: bit0 run (KEY[1]), bit1 step (KEY[2]), bit2 clear (KEY[3])
    task automatic press(input logic [2:0] keys, input int hold);
        if (hold >= DB_CYCLES) begin
            if (keys[0]) sq_run.push_back(cyc + 2 + DB_CYCLES);
            if (keys[1]) sq_step.push_back(cyc + 2 + DB_CYCLES);
            if (keys[2]) sq_clr.push_back(cyc + 2 + DB_CYCLES);
        end
        key[3:1] = ~keys;
        repeat (hold) @(negedge clk);
        key[3:1] = 3'b111;
        repeat (3) @(negedge clk);
    endtask

    // Lands a run/pause press exactly on the edge of the next tick (speed 0).
    task automatic pause_on_tick(input int budget);
        int i;
        i = 0;
        while (!(m_st == 1 && m_t == 0 && m_per == BASE_DIV) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) begin
            chk("pause_on_tick_timeout", i, 0);
        end else begin
            press(3'b001, DB_CYCLES);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 key[0] = 1'b0;
        #1;
        chk("async_reset_ledr", ledr, 0);
        chk("async_reset_ledg", ledg, 0);
        repeat (2) @(negedge clk);
        #2 key[0] = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        key = 4'b1110;
        sw  = 10'h000;
        repeat (3) @(negedge clk);
        chk("reset_ledr", ledr, 0);
        chk("reset_ledg", ledg, 0);
        #2 key[0] = 1'b1;
        @(negedge clk);

        // chaser at speed 0, step ignored in IDLE first
        press(3'b010, 2);
        wait_cycles(3);
        press(3'b001, 2);
        wait_cycles(40);
        chk("chaser_state_run", ledr[9:8], 2'b01);

        // pause, three steps, long hold, glitch
        press(3'b001, 2);
        wait_cycles(10);
        chk("paused_state", ledr[9:8], 2'b10);
        for (int i = 0; i < 3; i++) press(3'b010, 2);
        press(3'b010, 100);
        press(3'b010, 1);
        wait_cycles(10);

        // resume, then pause exactly on a tick
        press(3'b001, 2);
        pause_on_tick(50);
        wait_cycles(10);
        chk("pause_on_tick_state", ledr[9:8], 2'b10);

        // clear and run together while paused
        press(3'b101, 2);
        wait_cycles(5);
        chk("clear_run_ledr", ledr, 0);
        chk("clear_run_ledg", ledg, 0);

        // ping-pong, then slow down mid-period, then a mode change that must be ignored
        sw = 10'h001;
        press(3'b001, 2);
        wait_cycles(62);
        sw = 10'h041;
        wait_cycles(40);
        sw = 10'h043;
        wait_cycles(30);
        press(3'b100, 2);

        // stagger for 16+ ticks, mode switch mid-run ignored until clear+run
        sw = 10'h003;
        press(3'b001, 2);
        wait_cycles(70);
        sw = 10'h000;
        wait_cycles(20);
        press(3'b100, 2);
        press(3'b001, 2);
        wait_cycles(20);
        press(3'b100, 2);

        // binary count briefly
        sw = 10'h002;
        press(3'b001, 2);
        wait_cycles(30);

        // random mix of presses and switch changes
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 5) press(3'b001, $urandom_range(1, 4));
            else if (r < 8) press(3'b010, $urandom_range(1, 4));
            else if (r == 8) press(3'b100, $urandom_range(1, 3));
            else if (r == 9) press(3'($urandom_range(1, 7)), 2);
            else sw = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom_range(0, 3))};
            wait_cycles($urandom_range(0, 15));
        end

        // reset asserted mid-run
        press(3'b100, 2);
        sw = 10'h000;
        press(3'b001, 2);
        wait_cycles(15);
        async_reset();
        press(3'b001, 2);
        wait_cycles(12);

        wait_cycles(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
